scic_memory: RTL
================

# scic_memory

Memory responder for the single-accumulator CPU. It answers the CPU's address/data/write-enable bus with word RAM and a small memory-mapped I/O page. It also owns a streaming program loader that holds the CPU in reset while RAM is filled from an external word stream, then releases it. It sits between the CPU and the board top level.

## Interface
**Parameters**
- `ADDR_WIDTH`, default 8: RAM depth is 2^ADDR_WIDTH 32-bit words.
- `IO_PAGE`, default 8'hFF: value of `cpu_addr[15:8]` that selects the I/O page.

**Ports** (clock and reset first)
- `clock`  in  1: single clock. All state updates on its rising edge.
- `reset_n`  in  1: asynchronous, active-low reset.
- `cpu_addr`  in  16: word address from the CPU.
- `cpu_wdata`  in  32: store data from the CPU accumulator.
- `cpu_we`  in  1: CPU store strobe.
- `cpu_rdata`  out  32: read data to the CPU. Combinational from `cpu_addr`.
- `cpu_reset`  out  1: active-high synchronous reset for the CPU.
- `ld_valid`  in  1: loader word valid.
- `ld_data`  in  32: loader word.
- `ld_last`  in  1: marks the final loader word.
- `ld_ready`  out  1: loader accepts a word.
- `ld_restart`  in  1: one-cycle request to reload the program.
- `gpio_in`  in  8: asynchronous input pins.
- `gpio_out`  out  8: output register.

## Operation
- **State machine** `{LOAD, RUN}`. Reset enters LOAD.
- **LOAD state**
  - `cpu_reset`=1, `ld_ready`=1.
  - A beat (`ld_valid & ld_ready`) writes `ld_data` to RAM[`ld_ptr`] and increments `ld_ptr`.
  - A beat with `ld_last`=1, or a beat at `ld_ptr` = 2^ADDR_WIDTH−1, moves to RUN. `ld_ptr` then wraps to 0.
  - `cpu_we` is ignored in LOAD.
- **RUN state**
  - `cpu_reset`=0, `ld_ready`=0.
  - `ld_restart`=1 returns to LOAD with `ld_ptr`=0. Restart in LOAD is ignored.
- **Address decode**
  - `cpu_addr[15:8]==IO_PAGE` selects I/O.
  - Any other address selects RAM[`cpu_addr[ADDR_WIDTH-1:0]`]; upper bits alias.
- **I/O registers**, indexed by `cpu_addr[7:0]`:
  - 0x00 GPIO_OUT: read/write, 8 bits, zero-extended on read.
  - 0x01 GPIO_IN: read-only. `gpio_in` passed through a 2-flop synchronizer.
  - 0x02 CYCLES: 32-bit counter. Increments every RUN cycle and wraps at 2^32. A CPU write clears it to 0; a clear wins over an increment in the same cycle.
  - 0x03 STORES: 32-bit count of CPU stores to RAM in RUN. Read-only.
  - Other I/O offsets read 0; writes to them are dropped.
- **Reset values**
  - State=LOAD, `cpu_reset`=1, `ld_ready`=1, `ld_ptr`=0.
  - `gpio_out`=0, synchronizer flops=0, CYCLES=0, STORES=0.
  - RAM contents are not reset.

## Timing
- Read latency is zero. `cpu_rdata` is valid in the same cycle as `cpu_addr`, so the CPU samples it at the next edge.
- Writes commit at the rising edge where `cpu_we`=1.
- Read-during-write to the same address returns the old word in that cycle.
- `cpu_reset` is registered: it falls on the edge that accepts the last loader word. The CPU fetches RAM[0] on the following edge.
- `ld_restart` in RUN raises `cpu_reset` and `ld_ready` on the next edge. A CPU store on that same edge still commits.
- GPIO_IN reflects a pin change 2–3 edges later.
- `reset_n` low mid-load: the load aborts immediately. RAM keeps the partial image and `ld_ptr` returns to 0.

## Structure
- Package `scic_pkg` holds:
  - the state enum `{LOAD, RUN}`;
  - I/O offset constants `IO_GPIO_OUT`, `IO_GPIO_IN`, `IO_CYCLES`, `IO_STORES`;
  - the opcode constants shared with the CPU.
- Sub-module `scic_ram`: 2^ADDR_WIDTH×32 array with combinational read and a synchronous write port. The write port is muxed between the loader and the CPU by state.

## Test plan
- **Load and run:** stream 3 words `{40000005, 7000FF00, 80000000}` with `ld_last` on the third beat -> `cpu_reset` falls on that edge, and `gpio_out`=8'h05 within 6 cycles.
- **Full-depth load:** 256 beats with `ld_last`=0 -> RUN after beat 255, `ld_ptr`=0, RAM[255] holds the final word.
- **CYCLES:** read 0xFF02 after N RUN cycles -> returns N. A CPU store and an increment on the same edge -> reads 0 next cycle.
- **Aliasing:** store 0xDEADBEEF to address 0x0105 (ADDR_WIDTH=8) -> reading 0x0005 returns 0xDEADBEEF, and STORES increments by 1.
- **Restart:** pulse `ld_restart` in RUN -> `cpu_reset`=1 and `ld_ready`=1 next edge. A new image loads from address 0.
- **Reset mid-load:** assert `reset_n`=0 after 2 beats -> all outputs at reset values asynchronously, and a fresh load starts at `ld_ptr`=0.

Source files
------------

// File: rtl/scic_pkg.sv
// Shared definitions for the single-accumulator CPU memory subsystem:
// loader states, I/O page offsets and the instruction opcodes.
package scic_pkg;

    localparam int unsigned WORD_WIDTH   = 32;
    localparam int unsigned OFFS_WIDTH   = 8;
    localparam int unsigned OPCODE_WIDTH = 4;

    typedef enum logic {
        LOAD = 1'b0,
        RUN  = 1'b1
    } state_t;

    // I/O page register offsets (cpu_addr[7:0])
    localparam logic [OFFS_WIDTH-1:0] IO_GPIO_OUT = 8'h00;
    localparam logic [OFFS_WIDTH-1:0] IO_GPIO_IN  = 8'h01;
    localparam logic [OFFS_WIDTH-1:0] IO_CYCLES   = 8'h02;
    localparam logic [OFFS_WIDTH-1:0] IO_STORES   = 8'h03;

    // Opcodes live in the top nibble of an instruction word
    localparam logic [OPCODE_WIDTH-1:0] OP_NOP  = 4'h0;
    localparam logic [OPCODE_WIDTH-1:0] OP_ADD  = 4'h1;
    localparam logic [OPCODE_WIDTH-1:0] OP_SUB  = 4'h2;
    localparam logic [OPCODE_WIDTH-1:0] OP_LDA  = 4'h3;
    localparam logic [OPCODE_WIDTH-1:0] OP_LDI  = 4'h4;
    localparam logic [OPCODE_WIDTH-1:0] OP_AND  = 4'h5;
    localparam logic [OPCODE_WIDTH-1:0] OP_OR   = 4'h6;
    localparam logic [OPCODE_WIDTH-1:0] OP_STA  = 4'h7;
    localparam logic [OPCODE_WIDTH-1:0] OP_JMP  = 4'h8;
    localparam logic [OPCODE_WIDTH-1:0] OP_JZ   = 4'h9;
    localparam logic [OPCODE_WIDTH-1:0] OP_HALT = 4'hF;

    function automatic logic [OPCODE_WIDTH-1:0] opcode_of(input logic [WORD_WIDTH-1:0] word);
        return word[WORD_WIDTH-1 -: OPCODE_WIDTH];
    endfunction

endpackage

// File: rtl/scic_ram.sv
// Word RAM with combinational read and one synchronous write port that is
// owned by the loader in LOAD and by the CPU in RUN.
module scic_ram
    import scic_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 8
) (
    input  logic                  clock,
    input  state_t                state,
    input  logic                  ld_we,
    input  logic [ADDR_WIDTH-1:0] ld_addr,
    input  logic [WORD_WIDTH-1:0] ld_wdata,
    input  logic                  cpu_we,
    input  logic [ADDR_WIDTH-1:0] cpu_addr,
    input  logic [WORD_WIDTH-1:0] cpu_wdata,
    input  logic [ADDR_WIDTH-1:0] raddr,
    output logic [WORD_WIDTH-1:0] rdata
);

    localparam int unsigned DEPTH = 1 << ADDR_WIDTH;

    logic [WORD_WIDTH-1:0] mem [DEPTH];
    logic                  wr_en_c;
    logic [ADDR_WIDTH-1:0] wr_addr_c;
    logic [WORD_WIDTH-1:0] wr_data_c;

    // Write-port ownership follows the loader state
    always_comb begin
        wr_en_c   = ld_we;
        wr_addr_c = ld_addr;
        wr_data_c = ld_wdata;
        if (state == RUN) begin
            wr_en_c   = cpu_we;
            wr_addr_c = cpu_addr;
            wr_data_c = cpu_wdata;
        end
    end

    always_ff @(posedge clock) begin
        if (wr_en_c) begin
            mem[wr_addr_c] <= wr_data_c;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/scic_memory.sv
// CPU memory responder: word RAM, memory-mapped I/O page and a streaming
// program loader that holds the CPU in reset until the image is in RAM.
module scic_memory
    import scic_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 8,
    parameter logic [7:0]  IO_PAGE    = 8'hFF
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic [15:0] cpu_addr,
    input  logic [31:0] cpu_wdata,
    input  logic        cpu_we,
    output logic [31:0] cpu_rdata,
    output logic        cpu_reset,
    input  logic        ld_valid,
    input  logic [31:0] ld_data,
    input  logic        ld_last,
    output logic        ld_ready,
    input  logic        ld_restart,
    input  logic [7:0]  gpio_in,
    output logic [7:0]  gpio_out
);

    localparam logic [ADDR_WIDTH-1:0] LAST_PTR = '1;

    state_t                state;
    state_t                state_next;
    logic [ADDR_WIDTH-1:0] ld_ptr;
    logic [ADDR_WIDTH-1:0] ld_ptr_next;
    logic [7:0]            gpio_meta;
    logic [7:0]            gpio_sync;
    logic [31:0]           cycles;
    logic [31:0]           stores;
    logic [31:0]           ram_rdata;

    logic                  beat_c;
    logic                  io_sel_c;
    logic [7:0]            io_offs_c;
    logic                  cpu_store_c;
    logic                  ram_store_c;
    logic                  io_write_c;

    assign beat_c      = ld_valid && ld_ready;
    assign io_sel_c    = (cpu_addr[15:8] == IO_PAGE);
    assign io_offs_c   = cpu_addr[7:0];
    assign cpu_store_c = (state == RUN) && cpu_we;
    assign ram_store_c = cpu_store_c && !io_sel_c;
    assign io_write_c  = cpu_store_c && io_sel_c;

    // Loader FSM next state; the pointer restarts at 0 whenever RUN is entered or left
    always_comb begin
        state_next  = state;
        ld_ptr_next = ld_ptr;
        case (state)
            LOAD: begin
                if (beat_c) begin
                    if (ld_last || (ld_ptr == LAST_PTR)) begin
                        state_next  = RUN;
                        ld_ptr_next = '0;
                    end else begin
                        ld_ptr_next = ld_ptr + ADDR_WIDTH'(1);
                    end
                end
            end
            RUN: begin
                if (ld_restart) begin
                    state_next  = LOAD;
                    ld_ptr_next = '0;
                end
            end
        endcase
    end

    // cpu_reset/ld_ready follow the next state so they change on the transition edge
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state     <= LOAD;
            ld_ptr    <= '0;
            cpu_reset <= 1'b1;
            ld_ready  <= 1'b1;
        end else begin
            state     <= state_next;
            ld_ptr    <= ld_ptr_next;
            cpu_reset <= (state_next == LOAD);
            ld_ready  <= (state_next == LOAD);
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            gpio_out  <= '0;
            gpio_meta <= '0;
            gpio_sync <= '0;
            cycles    <= '0;
            stores    <= '0;
        end else begin
            gpio_meta <= gpio_in;
            gpio_sync <= gpio_meta;
            if (io_write_c && (io_offs_c == IO_GPIO_OUT)) begin
                gpio_out <= cpu_wdata[7:0];
            end
            // A CPU write to CYCLES takes priority over the RUN increment
            if (io_write_c && (io_offs_c == IO_CYCLES)) begin
                cycles <= '0;
            end else if (state == RUN) begin
                cycles <= cycles + 32'd1;
            end
            if (ram_store_c) begin
                stores <= stores + 32'd1;
            end
        end
    end

    scic_ram #(
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_ram (
        .clock     (clock),
        .state     (state),
        .ld_we     (beat_c),
        .ld_addr   (ld_ptr),
        .ld_wdata  (ld_data),
        .cpu_we    (ram_store_c),
        .cpu_addr  (cpu_addr[ADDR_WIDTH-1:0]),
        .cpu_wdata (cpu_wdata),
        .raddr     (cpu_addr[ADDR_WIDTH-1:0]),
        .rdata     (ram_rdata)
    );

    always_comb begin
        cpu_rdata = ram_rdata;
        if (io_sel_c) begin
            case (io_offs_c)
                IO_GPIO_OUT: cpu_rdata = {24'h0, gpio_out};
                IO_GPIO_IN:  cpu_rdata = {24'h0, gpio_sync};
                IO_CYCLES:   cpu_rdata = cycles;
                IO_STORES:   cpu_rdata = stores;
                default:     cpu_rdata = '0;
            endcase
        end
    end

endmodule
